// File: rtl/alu_arbiter.sv
// Round-robin arbiter sharing one combinational add/sub ALU between two requesters.
// Optional overflow event counter enabled by defining ALU_ARB_OVF_CNT_EN.
module alu_arbiter #(
  parameter int DATA_WIDTH = 32,
  parameter int OP_WIDTH   = 3
) (
  input  logic                  i_clk,
  input  logic                  i_rst,
  input  logic                  i_req0_valid,
  output logic                  o_req0_ready,
  input  logic [OP_WIDTH-1:0]   i_req0_op,
  input  logic [DATA_WIDTH-1:0] i_req0_a,
  input  logic [DATA_WIDTH-1:0] i_req0_b,
  input  logic                  i_req1_valid,
  output logic                  o_req1_ready,
  input  logic [OP_WIDTH-1:0]   i_req1_op,
  input  logic [DATA_WIDTH-1:0] i_req1_a,
  input  logic [DATA_WIDTH-1:0] i_req1_b,
  output logic                  o_rsp0_valid,
  input  logic                  i_rsp0_ready,
  output logic [DATA_WIDTH-1:0] o_rsp0_data,
  output logic                  o_rsp0_overflow,
  output logic                  o_rsp1_valid,
  input  logic                  i_rsp1_ready,
  output logic [DATA_WIDTH-1:0] o_rsp1_data,
  output logic                  o_rsp1_overflow,
  output logic [OP_WIDTH-1:0]   o_alu_op,
  output logic [DATA_WIDTH-1:0] o_alu_a,
  output logic [DATA_WIDTH-1:0] o_alu_b,
  input  logic [DATA_WIDTH-1:0] i_alu_data,
  input  logic                  i_alu_overflow,
  input  logic                  i_ovf_clr,
  output logic [15:0]           o_ovf_cnt
);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_EXEC = 2'd1,
    ST_RESP = 2'd2
  } state_e;

  localparam logic [OP_WIDTH-1:0]   OP_ADD    = {OP_WIDTH{1'b0}};
  localparam logic [OP_WIDTH-1:0]   OP_SUB    = {{(OP_WIDTH-1){1'b0}}, 1'b1};
  localparam logic [OP_WIDTH-1:0]   OP_ZERO   = {OP_WIDTH{1'b0}};
  localparam logic [DATA_WIDTH-1:0] DATA_ZERO = {DATA_WIDTH{1'b0}};

  state_e                state_q, state_d;
  logic                  prio_q, prio_d;
  logic                  owner_q, owner_d;
  logic [OP_WIDTH-1:0]   op_q, op_d;
  logic [DATA_WIDTH-1:0] a_q, a_d;
  logic [DATA_WIDTH-1:0] b_q, b_d;
  logic                  rsp0_valid_q, rsp0_valid_d;
  logic [DATA_WIDTH-1:0] rsp0_data_q, rsp0_data_d;
  logic                  rsp0_ovf_q, rsp0_ovf_d;
  logic                  rsp1_valid_q, rsp1_valid_d;
  logic [DATA_WIDTH-1:0] rsp1_data_q, rsp1_data_d;
  logic                  rsp1_ovf_q, rsp1_ovf_d;

  logic                  any_req_s;
  logic                  grant_s;
  logic                  accept_s;
  logic                  legal_op_s;
  logic [DATA_WIDTH-1:0] res_data_s;
  logic                  res_ovf_s;

  // Arbitration: prio_q names the port that wins a tie; grant is only offered in IDLE.
  always_comb begin
    any_req_s = i_req0_valid | i_req1_valid;
    if (i_req0_valid && i_req1_valid) begin
      grant_s = prio_q;
    end else if (i_req1_valid) begin
      grant_s = 1'b1;
    end else begin
      grant_s = 1'b0;
    end
    accept_s     = (state_q == ST_IDLE) && any_req_s && !i_rst;
    o_req0_ready = accept_s && !grant_s;
    o_req1_ready = accept_s && grant_s;
  end

  // Result qualification: an illegal opcode never reports data or overflow.
  always_comb begin
    legal_op_s = (op_q == OP_ADD) || (op_q == OP_SUB);
    if (legal_op_s) begin
      res_data_s = i_alu_data;
      res_ovf_s  = i_alu_overflow;
    end else begin
      res_data_s = DATA_ZERO;
      res_ovf_s  = 1'b0;
    end
  end

  // Next-state and datapath register update.
  always_comb begin
    state_d      = state_q;
    prio_d       = prio_q;
    owner_d      = owner_q;
    op_d         = op_q;
    a_d          = a_q;
    b_d          = b_q;
    rsp0_valid_d = rsp0_valid_q;
    rsp0_data_d  = rsp0_data_q;
    rsp0_ovf_d   = rsp0_ovf_q;
    rsp1_valid_d = rsp1_valid_q;
    rsp1_data_d  = rsp1_data_q;
    rsp1_ovf_d   = rsp1_ovf_q;
    case (state_q)
      ST_IDLE: begin
        if (accept_s) begin
          owner_d = grant_s;
          prio_d  = !grant_s;
          state_d = ST_EXEC;
          if (grant_s) begin
            op_d = i_req1_op;
            a_d  = i_req1_a;
            b_d  = i_req1_b;
          end else begin
            op_d = i_req0_op;
            a_d  = i_req0_a;
            b_d  = i_req0_b;
          end
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_EXEC: begin
        state_d = ST_RESP;
        if (owner_q) begin
          rsp1_valid_d = 1'b1;
          rsp1_data_d  = res_data_s;
          rsp1_ovf_d   = res_ovf_s;
        end else begin
          rsp0_valid_d = 1'b1;
          rsp0_data_d  = res_data_s;
          rsp0_ovf_d   = res_ovf_s;
        end
      end
      ST_RESP: begin
        if (owner_q && i_rsp1_ready) begin
          rsp1_valid_d = 1'b0;
          state_d      = ST_IDLE;
        end else if (!owner_q && i_rsp0_ready) begin
          rsp0_valid_d = 1'b0;
          state_d      = ST_IDLE;
        end else begin
          state_d = ST_RESP;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // Control state: FSM, round-robin pointer and owner id.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state_q <= ST_IDLE;
      prio_q  <= 1'b0;
      owner_q <= 1'b0;
    end else begin
      state_q <= state_d;
      prio_q  <= prio_d;
      owner_q <= owner_d;
    end
  end

  // Latched request operands.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      op_q <= OP_ZERO;
      a_q  <= DATA_ZERO;
      b_q  <= DATA_ZERO;
    end else begin
      op_q <= op_d;
      a_q  <= a_d;
      b_q  <= b_d;
    end
  end

  // Per-port response registers.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      rsp0_valid_q <= 1'b0;
      rsp0_data_q  <= DATA_ZERO;
      rsp0_ovf_q   <= 1'b0;
      rsp1_valid_q <= 1'b0;
      rsp1_data_q  <= DATA_ZERO;
      rsp1_ovf_q   <= 1'b0;
    end else begin
      rsp0_valid_q <= rsp0_valid_d;
      rsp0_data_q  <= rsp0_data_d;
      rsp0_ovf_q   <= rsp0_ovf_d;
      rsp1_valid_q <= rsp1_valid_d;
      rsp1_data_q  <= rsp1_data_d;
      rsp1_ovf_q   <= rsp1_ovf_d;
    end
  end

  assign o_rsp0_valid    = rsp0_valid_q;
  assign o_rsp0_data     = rsp0_data_q;
  assign o_rsp0_overflow = rsp0_ovf_q;
  assign o_rsp1_valid    = rsp1_valid_q;
  assign o_rsp1_data     = rsp1_data_q;
  assign o_rsp1_overflow = rsp1_ovf_q;

  // ALU pins carry the latched operation only during EXEC, otherwise quiet zeros.
  always_comb begin
    if (state_q == ST_EXEC) begin
      o_alu_op = op_q;
      o_alu_a  = a_q;
      o_alu_b  = b_q;
    end else begin
      o_alu_op = OP_ZERO;
      o_alu_a  = DATA_ZERO;
      o_alu_b  = DATA_ZERO;
    end
  end

`ifdef ALU_ARB_OVF_CNT_EN
  logic [15:0] ovf_cnt_q, ovf_cnt_d;

  // Saturating overflow event counter; clear has priority over an increment.
  always_comb begin
    ovf_cnt_d = ovf_cnt_q;
    if (i_ovf_clr) begin
      ovf_cnt_d = 16'h0000;
    end else if ((state_q == ST_EXEC) && res_ovf_s && (ovf_cnt_q != 16'hFFFF)) begin
      ovf_cnt_d = ovf_cnt_q + 16'h0001;
    end else begin
      ovf_cnt_d = ovf_cnt_q;
    end
  end

  // Overflow counter register.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      ovf_cnt_q <= 16'h0000;
    end else begin
      ovf_cnt_q <= ovf_cnt_d;
    end
  end

  assign o_ovf_cnt = ovf_cnt_q;
`else
  logic unused_ovf_clr_s;
  assign unused_ovf_clr_s = i_ovf_clr;
  assign o_ovf_cnt        = 16'h0000;
`endif

endmodule

// File: tb/tb_alu_arbiter.sv
// Self-checking bench for alu_arbiter: directed scenarios plus randomized traffic
// against a transaction-level reference model. Honours ALU_ARB_OVF_CNT_EN.
module tb_alu_arbiter;

  logic        i_clk;
  logic        i_rst;
  logic        i_req0_valid, i_req1_valid;
  logic        o_req0_ready, o_req1_ready;
  logic [2:0]  i_req0_op, i_req1_op;
  logic [31:0] i_req0_a, i_req0_b, i_req1_a, i_req1_b;
  logic        o_rsp0_valid, o_rsp1_valid;
  logic        i_rsp0_ready, i_rsp1_ready;
  logic [31:0] o_rsp0_data, o_rsp1_data;
  logic        o_rsp0_overflow, o_rsp1_overflow;
  logic [2:0]  o_alu_op;
  logic [31:0] o_alu_a, o_alu_b;
  logic [31:0] i_alu_data;
  logic        i_alu_overflow;
  logic        i_ovf_clr;
  logic [15:0] o_ovf_cnt;

  alu_arbiter #(.DATA_WIDTH(32), .OP_WIDTH(3)) dut (
    .i_clk(i_clk), .i_rst(i_rst),
    .i_req0_valid(i_req0_valid), .o_req0_ready(o_req0_ready), .i_req0_op(i_req0_op),
    .i_req0_a(i_req0_a), .i_req0_b(i_req0_b),
    .i_req1_valid(i_req1_valid), .o_req1_ready(o_req1_ready), .i_req1_op(i_req1_op),
    .i_req1_a(i_req1_a), .i_req1_b(i_req1_b),
    .o_rsp0_valid(o_rsp0_valid), .i_rsp0_ready(i_rsp0_ready), .o_rsp0_data(o_rsp0_data),
    .o_rsp0_overflow(o_rsp0_overflow),
    .o_rsp1_valid(o_rsp1_valid), .i_rsp1_ready(i_rsp1_ready), .o_rsp1_data(o_rsp1_data),
    .o_rsp1_overflow(o_rsp1_overflow),
    .o_alu_op(o_alu_op), .o_alu_a(o_alu_a), .o_alu_b(o_alu_b),
    .i_alu_data(i_alu_data), .i_alu_overflow(i_alu_overflow),
    .i_ovf_clr(i_ovf_clr), .o_ovf_cnt(o_ovf_cnt)
  );

  initial i_clk = 1'b0;
  always #5 i_clk = ~i_clk;

  // Stand-in ALU; illegal opcodes return junk so the arbiter's forcing is visible.
  always_comb begin
    if (o_alu_op == 3'd0) begin
      i_alu_data     = o_alu_a + o_alu_b;
      i_alu_overflow = (o_alu_a[31] == o_alu_b[31]) && (i_alu_data[31] != o_alu_a[31]);
    end else if (o_alu_op == 3'd1) begin
      i_alu_data     = o_alu_a - o_alu_b;
      i_alu_overflow = (o_alu_a[31] != o_alu_b[31]) && (i_alu_data[31] != o_alu_a[31]);
    end else begin
      i_alu_data     = o_alu_a ^ o_alu_b ^ 32'hA5A5_0001;
      i_alu_overflow = 1'b1;
    end
  end

  int          n_tests = 0;
  int          n_fail  = 0;
  logic        v[2];
  logic [2:0]  opv[2];
  logic [31:0] av[2], bv[2];
  logic        rr[2];
  logic        clr;
  int          last_g;
  logic [15:0] exp_cnt;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic drive();
    i_req0_valid = v[0]; i_req0_op = opv[0]; i_req0_a = av[0]; i_req0_b = bv[0];
    i_req1_valid = v[1]; i_req1_op = opv[1]; i_req1_a = av[1]; i_req1_b = bv[1];
    i_rsp0_ready = rr[0]; i_rsp1_ready = rr[1]; i_ovf_clr = clr;
  endtask

  // Reference: signed arithmetic in a wide integer; {overflow, data}.
  function automatic logic [32:0] ref_fn(input logic [2:0] op, input logic [31:0] a,
                                         input logic [31:0] b);
    longint sa, sb, r;
    logic [31:0] lo;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    if (op == 3'd0) r = sa + sb;
    else if (op == 3'd1) r = sa - sb;
    else return 33'd0;
    lo = r[31:0];
    return {(r > 64'sd2147483647) || (r < -64'sd2147483648), lo};
  endfunction

  function automatic logic [31:0] rnd_val();
    case ($urandom_range(0, 4))
      0: return 32'h7FFF_FFFF;
      1: return 32'h8000_0000;
      2: return 32'hFFFF_FFFF;
      default: return $urandom();
    endcase
  endfunction

  function automatic logic [2:0] rnd_op();
    if ($urandom_range(0, 3) == 0) return 3'($urandom_range(2, 7));
    return 3'($urandom_range(0, 1));
  endfunction

  task automatic set_req(input int p, input logic [2:0] op, input logic [31:0] a,
                         input logic [31:0] b);
    v[p] = 1'b1; opv[p] = op; av[p] = a; bv[p] = b;
  endtask

  // One full transaction starting at an IDLE sample point; hold = cycles of back-pressure.
  task automatic run_txn(input int hold, input logic clr_at_exec);
    int g;
    logic [32:0] r;
    drive();
    #1;
    if (!v[0] && !v[1]) begin
      chk("idle_req0_ready", o_req0_ready, 1'b0);
      chk("idle_req1_ready", o_req1_ready, 1'b0);
      @(posedge i_clk); #1;
      return;
    end
    g = (v[0] && v[1]) ? ((last_g == 0) ? 1 : 0) : (v[1] ? 1 : 0);
    chk("req0_ready", o_req0_ready, g == 0);
    chk("req1_ready", o_req1_ready, g == 1);
    r = ref_fn(opv[g], av[g], bv[g]);
    last_g = g;
    @(posedge i_clk); #1;
    v[g] = 1'b0;
    clr  = clr_at_exec;
    drive();
    #1;
    chk("exec_alu_op", o_alu_op, opv[g]);
    chk("exec_alu_a", o_alu_a, av[g]);
    chk("exec_alu_b", o_alu_b, bv[g]);
    chk("exec_req_ready", {o_req1_ready, o_req0_ready}, 2'b00);
    chk("exec_rsp_valid", {o_rsp1_valid, o_rsp0_valid}, 2'b00);
    @(posedge i_clk); #1;
`ifdef ALU_ARB_OVF_CNT_EN
    if (clr) exp_cnt = 16'h0000;
    else if (r[32] && exp_cnt != 16'hFFFF) exp_cnt = exp_cnt + 16'h0001;
`endif
    clr = 1'b0;
    drive();
    for (int k = 0; k <= hold; k++) begin
      chk("rsp_valid", {o_rsp1_valid, o_rsp0_valid}, (g == 1) ? 2'b10 : 2'b01);
      chk("rsp_data", (g == 1) ? o_rsp1_data : o_rsp0_data, r[31:0]);
      chk("rsp_overflow", (g == 1) ? o_rsp1_overflow : o_rsp0_overflow, r[32]);
      chk("resp_req_ready", {o_req1_ready, o_req0_ready}, 2'b00);
      chk("alu_idle_resp", o_alu_a | o_alu_b, 32'd0);
      chk("ovf_cnt", o_ovf_cnt, exp_cnt);
      rr[g] = (k == hold);
      drive();
      @(posedge i_clk); #1;
    end
    rr[g] = 1'b0;
    drive();
    chk("rsp_consumed", {o_rsp1_valid, o_rsp0_valid}, 2'b00);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    for (int p = 0; p < 2; p++) begin
      v[p] = 1'b0; opv[p] = 3'd0; av[p] = 32'd0; bv[p] = 32'd0; rr[p] = 1'b0;
    end
    clr = 1'b0; last_g = 1; exp_cnt = 16'h0000;
    i_rst = 1'b1;
    drive();
    @(posedge i_clk); @(posedge i_clk); #1;
    chk("rst_rsp_valid", {o_rsp1_valid, o_rsp0_valid}, 2'b00);
    chk("rst_rsp_data", o_rsp0_data | o_rsp1_data, 32'd0);
    chk("rst_alu", o_alu_a | o_alu_b | {29'd0, o_alu_op}, 32'd0);
    chk("rst_cnt", o_ovf_cnt, 16'h0000);
    i_rst = 1'b0;

    // Single ADD with signed overflow on port 0.
    set_req(0, 3'd0, 32'h7FFF_FFFF, 32'h0000_0001);
    run_txn(0, 1'b0);
    // SUB on port 1 going negative.
    set_req(1, 3'd1, 32'd5, 32'd7);
    run_txn(0, 1'b0);
    // Illegal opcode returns zero, no overflow, counter untouched.
    set_req(0, 3'd3, 32'd1, 32'd1);
    run_txn(0, 1'b0);
    // Overflow capture with a simultaneous clear.
    set_req(1, 3'd0, 32'h8000_0000, 32'hFFFF_FFFF);
    run_txn(0, 1'b1);
    // Back-pressure on port 0 while port 1 waits.
    set_req(0, 3'd1, 32'h8000_0000, 32'd1);
    set_req(1, 3'd0, 32'd100, 32'd23);
    run_txn(10, 1'b0);
    run_txn(0, 1'b0);

    // Reset asserted for two cycles while a port 0 response is pending.
    set_req(0, 3'd0, 32'd3, 32'd4);
    drive(); #1;
    chk("pre_rst_req0_ready", o_req0_ready, 1'b1);
    @(posedge i_clk); #1;
    v[0] = 1'b0; drive();
    @(posedge i_clk); #1;
    chk("pre_rst_rsp0_valid", o_rsp0_valid, 1'b1);
    i_rst = 1'b1;
    @(posedge i_clk); #1;
    chk("midrst_rsp", {o_rsp1_valid, o_rsp0_valid, o_rsp0_overflow}, 3'b000);
    chk("midrst_data", o_rsp0_data, 32'd0);
    chk("midrst_ready", {o_req1_ready, o_req0_ready}, 2'b00);
    chk("midrst_alu", o_alu_a | o_alu_b | {29'd0, o_alu_op}, 32'd0);
    chk("midrst_cnt", o_ovf_cnt, 16'h0000);
    @(posedge i_clk); #1;
    i_rst = 1'b0; exp_cnt = 16'h0000; last_g = 1;
    rr[0] = 1'b1; rr[1] = 1'b1; drive();
    for (int k = 0; k < 3; k++) begin
      chk("post_rst_no_rsp", {o_rsp1_valid, o_rsp0_valid}, 2'b00);
      @(posedge i_clk); #1;
    end
    rr[0] = 1'b0; rr[1] = 1'b0;

    // Continuous contention: both ports always valid, grants must alternate from port 0.
    set_req(0, rnd_op(), rnd_val(), rnd_val());
    set_req(1, rnd_op(), rnd_val(), rnd_val());
    for (int i = 0; i < 4; i++) begin
      run_txn(0, 1'b0);
      set_req(last_g, rnd_op(), rnd_val(), rnd_val());
    end

    // Randomized traffic with random back-pressure, drops and clears.
    for (int i = 0; i < 60; i++) begin
      for (int p = 0; p < 2; p++) begin
        if (v[p] && $urandom_range(0, 7) == 0) v[p] = 1'b0;
        else if (!v[p] && $urandom_range(0, 1) == 1) set_req(p, rnd_op(), rnd_val(), rnd_val());
      end
      run_txn(int'($urandom_range(0, 3)), ($urandom_range(0, 9) == 0));
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/alu_arbiter.md
Name: alu_arbiter

Overview:
- Shares one combinational add/sub ALU between two requesters (port 0, port 1).
- Round-robin arbitration, valid/ready request handshake, registered per-port response with valid/ready.
- Drives the ALU operand/op pins and captures its result and overflow.
- Sits between the core's issue logic or accelerator front-ends and the ALU instance.

Parameters:
DATA_WIDTH, 32, operand/result width
OP_WIDTH, 3, ALU opcode width (0 = ADD, 1 = SUB, others = illegal)

Ports:
i_clk  input  1  clock, all state updates on rising edge
i_rst  input  1  reset, synchronous, active-high
i_req0_valid  input  1  port 0 request valid
o_req0_ready  output  1  port 0 request accepted this cycle
i_req0_op  input  OP_WIDTH  port 0 opcode
i_req0_a  input  DATA_WIDTH  port 0 operand a
i_req0_b  input  DATA_WIDTH  port 0 operand b
i_req1_valid / o_req1_ready / i_req1_op / i_req1_a / i_req1_b  same as port 0, for port 1
o_rsp0_valid  output  1  port 0 response valid
i_rsp0_ready  input  1  port 0 response consumed
o_rsp0_data  output  DATA_WIDTH  port 0 result
o_rsp0_overflow  output  1  port 0 signed overflow
o_rsp1_valid / i_rsp1_ready / o_rsp1_data / o_rsp1_overflow  same as port 0, for port 1
o_alu_op  output  OP_WIDTH  to ALU i_op
o_alu_a  output  DATA_WIDTH  to ALU i_data_a
o_alu_b  output  DATA_WIDTH  to ALU i_data_b
i_alu_data  input  DATA_WIDTH  from ALU o_data
i_alu_overflow  input  1  from ALU o_overflow
i_ovf_clr  input  1  clears overflow counter (optional feature)
o_ovf_cnt  output  16  overflow event count (optional feature)

Behaviour:
- Reset: one clock, synchronous, active-high. While i_rst is high at a rising edge:
  - state goes to IDLE; the round-robin pointer favours port 0.
  - all outputs go to 0: every o_*_valid, o_*_ready, o_rsp*_data, o_rsp*_overflow, o_alu_*, o_ovf_cnt.
  - any in-flight or unconsumed operation is discarded, with no response.
- FSM states: IDLE, EXEC, RESP.
- IDLE:
  - Grant = the requester with valid; if both are valid, the one not granted last.
  - o_reqN_ready is asserted combinationally only for the granted N, and only in IDLE.
  - On handshake (valid & ready): latch op/a/b and the owner id, flip the pointer to favour the other port, go to EXEC.
  - No valid: stay in IDLE.
- EXEC (1 cycle):
  - o_alu_op/a/b driven from the latched registers. Outside EXEC they are 0.
  - At the edge: capture i_alu_data and i_alu_overflow into the owner's response registers, set o_rspN_valid, go to RESP.
  - Illegal op (value > 1): force data 0 and overflow 0, whatever the ALU returns.
- RESP:
  - Hold o_rspN_valid, data and overflow stable until i_rspN_ready is high at an edge.
  - Then clear valid and go to IDLE. The non-owner's rsp valid stays 0.
- Latency and throughput: accept at edge T, rsp valid from T+1. Minimum 3 cycles per op when rsp_ready is held high. No new request is accepted while in EXEC or RESP.
- Requester rule: valid with stable op/a/b must be held until ready. Dropping valid before grant is legal and ignored.
- Back-pressure: a response held indefinitely blocks both ports (no starvation guarantee beyond round-robin).
- Arithmetic: the block does no arithmetic; width is DATA_WIDTH throughout, with no extension.

Optional Feature:
- Macro: ALU_ARB_OVF_CNT_EN.
- When defined:
  - o_ovf_cnt increments by 1 on each EXEC cycle with captured overflow = 1 (legal ops only).
  - Saturates at 16'hFFFF.
  - i_ovf_clr high at an edge sets it to 0; clear wins over a simultaneous increment.
  - Reset sets it to 0.
- When undefined: o_ovf_cnt is constant 0, i_ovf_clr is ignored, and no counter flops exist.

Test Plan:
1. Reset: assert i_rst 2 cycles mid-RESP with o_rsp0_valid=1 -> next edge all outputs 0, state IDLE, no response emitted after release.
2. Single op: port0 op=0, a=32'h7FFF_FFFF, b=1, rsp_ready=1 -> ready at T, o_alu_a/b driven at T+1, o_rsp0_data=32'h8000_0000, overflow=1 during T+1..T+2, o_ovf_cnt=1 with macro.
3. SUB: port1 op=1, a=5, b=7 -> o_rsp1_data=32'hFFFF_FFFE, overflow=0; o_rsp0_valid stays 0.
4. Contention: both valid continuously after reset, rsp_ready=1 -> grants 0,1,0,1 on accepts every 3 cycles; each response goes to the correct port with its own operands.
5. Back-pressure: port0 rsp_ready=0 for 10 cycles with port1 valid -> o_rsp0_valid and data held stable, o_req1_ready=0 throughout; port1 is granted the cycle after rsp0 is consumed.
6. Illegal op=3, a=1, b=1 -> data=0, overflow=0, counter unchanged; ALU_ARB_OVF_CNT_EN build with i_ovf_clr pulsed at the same edge as an overflow capture -> o_ovf_cnt=0.
